// File: rtl/hazard_pkg.sv
// Shared types, constants and helpers for the load-use hazard / stall controller.
package hazard_pkg;

    localparam int REG_ADDR_W_DEF = 5;
    localparam int ZERO_REG       = 0;
    localparam int WAIT_W         = 4;

    typedef enum logic {
        RUN       = 1'b0,
        LOAD_WAIT = 1'b1
    } state_t;

    // Increment v, holding at all-ones of a w-bit counter (w <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [63:0] top;
        top = (64'd1 << w) - 64'd1;
        return ({32'd0, v} >= top) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/hazard_reg_match.sv
// Compares one source register specifier against one producer destination,
// qualified by the source's use-enable and excluding register $0.
module hazard_reg_match
    import hazard_pkg::*;
#(
    parameter int W = REG_ADDR_W_DEF
) (
    input  logic [W-1:0] src,
    input  logic         use_src,
    input  logic [W-1:0] dst,
    output logic         match
);

    assign match = use_src & (src == dst) & (src != W'(ZERO_REG));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use hazard detector with a configurable load latency, branch flush
// arbitration and saturating statistics. Optional macro HAZARD_BRANCH_OPERAND_EN
// adds branch-operand hazards against EX and MEM producers.
//
// state     | meaning
// RUN       | normal issue; stall only when a hazard is detected this cycle
// LOAD_WAIT | holding the stall until wait_cnt runs out
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
`ifdef HAZARD_BRANCH_OPERAND_EN
    input  logic                  id_ex_regwrite_i,
    input  logic [REG_ADDR_W-1:0] id_ex_rd_i,
    input  logic                  ex_mem_memread_i,
    input  logic [REG_ADDR_W-1:0] ex_mem_rt_i,
    input  logic                  if_id_branch_i,
`endif
    input  logic [REG_ADDR_W-1:0] if_id_rs_i,
    input  logic [REG_ADDR_W-1:0] if_id_rt_i,
    input  logic                  if_id_use_rs_i,
    input  logic                  if_id_use_rt_i,
    input  logic [REG_ADDR_W-1:0] id_ex_rt_i,
    input  logic                  id_ex_memread_i,
    input  logic                  branch_taken_i,
    output logic                  pc_write_o,
    output logic                  if_id_write_o,
    output logic                  id_ex_flush_o,
    output logic                  if_id_flush_o,
    output logic                  hazard_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
);

    localparam logic              MULTI    = (LOAD_LAT > 1);
    localparam logic [WAIT_W-1:0] LAT_M1   = WAIT_W'(LOAD_LAT - 1);

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              rs_ld, rt_ld, detect;
    logic              run_stall, enter_wait;
    logic [WAIT_W-1:0] wait_load;
    logic              stall, flush;

    hazard_reg_match #(.W(REG_ADDR_W)) u_rs_ld (
        .src(if_id_rs_i), .use_src(if_id_use_rs_i), .dst(id_ex_rt_i), .match(rs_ld)
    );
    hazard_reg_match #(.W(REG_ADDR_W)) u_rt_ld (
        .src(if_id_rt_i), .use_src(if_id_use_rt_i), .dst(id_ex_rt_i), .match(rt_ld)
    );

    assign detect = id_ex_memread_i & (rs_ld | rt_ld);

`ifdef HAZARD_BRANCH_OPERAND_EN
    localparam logic [WAIT_W-1:0] LAT_FULL = WAIT_W'(LOAD_LAT);

    logic rs_alu, rt_alu, rs_mem, rt_mem;
    logic br_alu, br_mem, br_ld;

    hazard_reg_match #(.W(REG_ADDR_W)) u_rs_alu (
        .src(if_id_rs_i), .use_src(if_id_use_rs_i), .dst(id_ex_rd_i), .match(rs_alu)
    );
    hazard_reg_match #(.W(REG_ADDR_W)) u_rt_alu (
        .src(if_id_rt_i), .use_src(if_id_use_rt_i), .dst(id_ex_rd_i), .match(rt_alu)
    );
    hazard_reg_match #(.W(REG_ADDR_W)) u_rs_mem (
        .src(if_id_rs_i), .use_src(if_id_use_rs_i), .dst(ex_mem_rt_i), .match(rs_mem)
    );
    hazard_reg_match #(.W(REG_ADDR_W)) u_rt_mem (
        .src(if_id_rt_i), .use_src(if_id_use_rt_i), .dst(ex_mem_rt_i), .match(rt_mem)
    );

    assign br_alu = if_id_branch_i & id_ex_regwrite_i & ~id_ex_memread_i & (rs_alu | rt_alu);
    assign br_mem = if_id_branch_i & ex_mem_memread_i & (rs_mem | rt_mem);
    // A branch behind an EX load needs one cycle more than a normal consumer.
    assign br_ld  = if_id_branch_i & detect;

    assign run_stall  = detect | br_alu | br_mem;
    assign enter_wait = br_ld | (detect & MULTI);
    assign wait_load  = br_ld ? LAT_FULL : LAT_M1;
`else
    assign run_stall  = detect;
    assign enter_wait = detect & MULTI;
    assign wait_load  = LAT_M1;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (enter_wait) begin
                        state    <= LOAD_WAIT;
                        wait_cnt <= wait_load;
                    end
                end
                LOAD_WAIT: begin
                    wait_cnt <= wait_cnt - 1'b1;
                    if (wait_cnt == WAIT_W'(1)) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    // Reset gates the controls so an in-flight stall is dropped immediately.
    assign stall = rst_i & ((state == LOAD_WAIT) | run_stall);
    assign flush = rst_i & branch_taken_i & ~stall;

    assign pc_write_o    = ~stall;
    assign if_id_write_o = ~stall;
    assign id_ex_flush_o = stall;
    assign hazard_o      = stall;
    assign if_id_flush_o = flush;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (stall) begin
                stall_cnt_o <= CNT_W'(sat_inc(32'(stall_cnt_o), CNT_W));
            end
            if (flush) begin
                flush_cnt_o <= CNT_W'(sat_inc(32'(flush_cnt_o), CNT_W));
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench: three controller instances (LOAD_LAT 1/3/4, one with
// 4-bit counters) driven in parallel and compared against a cycle model.
module tb_hazard_stall_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [4:0] rs, rt, ex_rt;
    logic       use_rs, use_rt, memread, br;

    wire [4:0]  ctl0, ctl1, ctl2;
    wire [15:0] sc0, fc0, sc1, fc1;
    wire [3:0]  sc2, fc2;

    int checks   = 0;
    int failures = 0;

    int lat [3] = '{1, 3, 4};
    int cw  [3] = '{16, 16, 4};
    int rem [3];
    int msc [3];
    int mfc [3];

    localparam int C_STALL = 5'b10010;
    localparam int C_FLUSH = 5'b01101;
    localparam int C_IDLE  = 5'b01100;

`ifdef HAZARD_BRANCH_OPERAND_EN
`define TB_EXTRA .id_ex_regwrite_i(1'b0), .id_ex_rd_i(5'd0), .ex_mem_memread_i(1'b0), .ex_mem_rt_i(5'd0), .if_id_branch_i(1'b0),
`else
`define TB_EXTRA
`endif

    hazard_stall_ctrl #(.LOAD_LAT(1), .CNT_W(16)) dut_a (
        .clk_i(clk), .rst_i(rst_n), `TB_EXTRA
        .if_id_rs_i(rs), .if_id_rt_i(rt), .if_id_use_rs_i(use_rs), .if_id_use_rt_i(use_rt),
        .id_ex_rt_i(ex_rt), .id_ex_memread_i(memread), .branch_taken_i(br),
        .pc_write_o(ctl0[3]), .if_id_write_o(ctl0[2]), .id_ex_flush_o(ctl0[1]),
        .if_id_flush_o(ctl0[0]), .hazard_o(ctl0[4]), .stall_cnt_o(sc0), .flush_cnt_o(fc0)
    );
    hazard_stall_ctrl #(.LOAD_LAT(3), .CNT_W(16)) dut_b (
        .clk_i(clk), .rst_i(rst_n), `TB_EXTRA
        .if_id_rs_i(rs), .if_id_rt_i(rt), .if_id_use_rs_i(use_rs), .if_id_use_rt_i(use_rt),
        .id_ex_rt_i(ex_rt), .id_ex_memread_i(memread), .branch_taken_i(br),
        .pc_write_o(ctl1[3]), .if_id_write_o(ctl1[2]), .id_ex_flush_o(ctl1[1]),
        .if_id_flush_o(ctl1[0]), .hazard_o(ctl1[4]), .stall_cnt_o(sc1), .flush_cnt_o(fc1)
    );
    hazard_stall_ctrl #(.LOAD_LAT(4), .CNT_W(4)) dut_c (
        .clk_i(clk), .rst_i(rst_n), `TB_EXTRA
        .if_id_rs_i(rs), .if_id_rt_i(rt), .if_id_use_rs_i(use_rs), .if_id_use_rt_i(use_rt),
        .id_ex_rt_i(ex_rt), .id_ex_memread_i(memread), .branch_taken_i(br),
        .pc_write_o(ctl2[3]), .if_id_write_o(ctl2[2]), .id_ex_flush_o(ctl2[1]),
        .if_id_flush_o(ctl2[0]), .hazard_o(ctl2[4]), .stall_cnt_o(sc2), .flush_cnt_o(fc2)
    );

    function automatic int dut_ctl(int i);
        case (i)
            0:       return int'(ctl0);
            1:       return int'(ctl1);
            default: return int'(ctl2);
        endcase
    endfunction

    function automatic int dut_sc(int i);
        case (i)
            0:       return int'(sc0);
            1:       return int'(sc1);
            default: return int'(sc2);
        endcase
    endfunction

    function automatic int dut_fc(int i);
        case (i)
            0:       return int'(fc0);
            1:       return int'(fc1);
            default: return int'(fc2);
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int a_rs, input int a_urs, input int a_rt, input int a_urt,
                         input int a_ex, input int a_mr, input int a_br);
        rs = 5'(a_rs); use_rs = a_urs[0]; rt = 5'(a_rt); use_rt = a_urt[0];
        ex_rt = 5'(a_ex); memread = a_mr[0]; br = a_br[0];
    endtask

    // Check all instances against the model, then advance one clock.
    task automatic cyc();
        bit det, stl, fl;
        int nrem [3];
        int nsc  [3];
        int nfc  [3];
        int top;
        #1;
        det = memread && ((use_rs && rs == ex_rt && rs != 0) ||
                          (use_rt && rt == ex_rt && rt != 0));
        for (int i = 0; i < 3; i++) begin
            stl = (rem[i] > 0) || det;
            fl  = br && !stl;
            chk($sformatf("ctl%0d", i), dut_ctl(i), stl ? C_STALL : (fl ? C_FLUSH : C_IDLE));
            chk($sformatf("stall_cnt%0d", i), dut_sc(i), msc[i]);
            chk($sformatf("flush_cnt%0d", i), dut_fc(i), mfc[i]);
            top     = (1 << cw[i]) - 1;
            nrem[i] = (rem[i] > 0) ? rem[i] - 1 : (det ? lat[i] - 1 : 0);
            nsc[i]  = (stl && msc[i] < top) ? msc[i] + 1 : msc[i];
            nfc[i]  = (fl && mfc[i] < top) ? mfc[i] + 1 : mfc[i];
        end
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            rem[i] = nrem[i];
            msc[i] = nsc[i];
            mfc[i] = nfc[i];
        end
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            rem[i] = 0; msc[i] = 0; mfc[i] = 0;
        end
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_ctl%0d", i), dut_ctl(i), C_IDLE);
            chk($sformatf("rst_sc%0d", i), dut_sc(i), 0);
            chk($sformatf("rst_fc%0d", i), dut_fc(i), 0);
        end
        #1 rst_n = 1'b1;
        model_clear();
    endtask

    typedef struct {
        int v_rs, v_urs, v_rt, v_urt, v_ex, v_mr, v_br;
        int exp_ctl;
    } vec_t;

    vec_t tbl [9];

    initial begin
        tbl[0] = '{5, 1, 0, 0, 5, 1, 0, C_STALL};
        tbl[1] = '{0, 1, 0, 0, 0, 1, 0, C_IDLE};
        tbl[2] = '{3, 1, 7, 0, 7, 1, 0, C_IDLE};
        tbl[3] = '{3, 1, 7, 1, 7, 1, 0, C_STALL};
        tbl[4] = '{5, 1, 0, 0, 5, 0, 0, C_IDLE};
        tbl[5] = '{1, 1, 2, 1, 3, 1, 1, C_FLUSH};
        tbl[6] = '{4, 1, 2, 1, 4, 1, 1, C_STALL};
        tbl[7] = '{9, 0, 2, 1, 9, 1, 0, C_IDLE};
        tbl[8] = '{0, 0, 0, 0, 0, 0, 0, C_IDLE};

        model_clear();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        #3;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("init_ctl%0d", i), dut_ctl(i), C_IDLE);
            chk($sformatf("init_sc%0d", i), dut_sc(i), 0);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single load-use hazard: 1, 3 and 4 stall cycles across the instances.
        drive(5, 1, 0, 0, 5, 1, 0);
        #1 chk("t1_stall_a", dut_ctl(0), C_STALL);
        cyc();
        chk("t1_sc_a", dut_sc(0), 1);
        memread = 1'b0;
        #1 chk("t1_idle_a", dut_ctl(0), C_IDLE);
        repeat (4) cyc();
        chk("t1_sc_b", dut_sc(1), 3);
        chk("t1_sc_c", dut_sc(2), 4);
        chk("t1_idle_b", dut_ctl(1), C_IDLE);

        do_reset();
        for (int k = 0; k < 9; k++) begin
            drive(tbl[k].v_rs, tbl[k].v_urs, tbl[k].v_rt, tbl[k].v_urt,
                  tbl[k].v_ex, tbl[k].v_mr, tbl[k].v_br);
            #1 chk($sformatf("tbl%0d", k), dut_ctl(0), tbl[k].exp_ctl);
            cyc();
        end
        repeat (4) cyc();

        // Flush alone, then flush suppressed by a coincident stall.
        do_reset();
        drive(1, 1, 2, 1, 3, 0, 1);
        cyc();
        chk("flush_cnt_a", dut_fc(0), 1);
        drive(4, 1, 0, 0, 4, 1, 1);
        #1 chk("flush_vs_stall_a", dut_ctl(0), C_STALL);
        cyc();
        chk("flush_hold_a", dut_fc(0), 1);
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (4) cyc();

        // Asynchronous reset in the second LOAD_WAIT cycle of the LOAD_LAT=4 instance.
        do_reset();
        drive(6, 1, 0, 0, 6, 1, 0);
        cyc();
        memread = 1'b0;
        cyc();
        chk("mid_wait_c", dut_ctl(2), C_STALL);
        #1 rst_n = 1'b0;
        #1 chk("async_rst_ctl_c", dut_ctl(2), C_IDLE);
        chk("async_rst_sc_c", dut_sc(2), 0);
        #1 rst_n = 1'b1;
        model_clear();
        repeat (2) cyc();

        // 20 consecutive stall cycles saturate the 4-bit counter.
        do_reset();
        drive(8, 1, 0, 0, 8, 1, 0);
        repeat (20) cyc();
        chk("sat_c", dut_sc(2), 15);
        chk("nosat_a", dut_sc(0), 20);
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (4) cyc();

        do_reset();
        for (int n = 0; n < 400; n++) begin
            drive(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? 1 : 0);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
